// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and constants for the multiplexed MCU bus initiator
package fsmc_pkg;

  localparam int AD_W   = 16;
  localparam int ADDR_W = 19;

  localparam int DEF_ADDSET  = 2;
  localparam int DEF_ADDHLD  = 1;
  localparam int DEF_DATAST  = 4;
  localparam int DEF_BUSTURN = 1;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AHOLD,
    ST_DATA,
    ST_TURN
  } fsmc_state_e;

endpackage

// File: rtl/fsmc_phase_cnt.sv
// rtl/fsmc_phase_cnt.sv - loadable phase down-counter with last-cycle flag
//   clk, rst     : clock, synchronous active-high reset
//   load         : load load_val (phase length - 1) at this edge
//   freeze       : hold the current count
//   last         : count is zero, i.e. this is the final cycle of the phase
module fsmc_phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             freeze,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!freeze) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/fsmc_mux_master.sv
// rtl/fsmc_mux_master.sv - initiator for the 16-bit multiplexed address/data MCU bus
//   CLK, RST            : clock, synchronous active-high reset
//   REQ, WR, ADDR, WDATA: request and its captured parameters (sampled while BUSY=0)
//   BUSY, DONE, RDATA   : status, one-cycle completion pulse, read data
//   NE, NADV, NOE, NWE  : active-low bus strobes
//   A16..A18, AD_OUT    : address/data drive; AD_OE enables the AD pad driver
//   AD_IN               : AD pad input
//   NWAIT               : active-low wait input, present only with FSMC_NWAIT_EN
module fsmc_mux_master
  import fsmc_pkg::*;
#(
  parameter int ADDSET  = DEF_ADDSET,
  parameter int ADDHLD  = DEF_ADDHLD,
  parameter int DATAST  = DEF_DATAST,
  parameter int BUSTURN = DEF_BUSTURN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [AD_W-1:0]   WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [AD_W-1:0]   RDATA,
  output logic              NE,
  output logic              NADV,
  output logic              NOE,
  output logic              NWE,
  output logic              A16,
  output logic              A17,
  output logic              A18,
  output logic [AD_W-1:0]   AD_OUT,
  output logic              AD_OE,
  input  logic [AD_W-1:0]   AD_IN
`ifdef FSMC_NWAIT_EN
  ,
  input  logic              NWAIT
`endif
);

  if (ADDSET < 1 || ADDHLD < 1 || DATAST < 1 || BUSTURN < 1) begin : g_zero_timing
    $error("fsmc_mux_master: timing parameters must be at least 1");
  end
  if (ADDSET > (1 << CNT_W) || ADDHLD > (1 << CNT_W) ||
      DATAST > (1 << CNT_W) || BUSTURN > (1 << CNT_W)) begin : g_wide_timing
    $error("fsmc_mux_master: timing parameter exceeds counter range");
  end

  localparam logic [CNT_W-1:0] ADDSET_LD  = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] ADDHLD_LD  = CNT_W'(ADDHLD - 1);
  localparam logic [CNT_W-1:0] DATAST_LD  = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] BUSTURN_LD = CNT_W'(BUSTURN - 1);

  fsmc_state_e       state, state_d;
  logic              pending, pending_d;
  logic              accept, rd_capture, done_d, busy_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [AD_W-1:0]   wdata_q;
  logic              cnt_load, cnt_freeze, cnt_last;
  logic [CNT_W-1:0]  cnt_val;
  logic              nwait_ok;
  logic              ne_d, nadv_d, noe_d, nwe_d, ad_oe_d;
  logic [AD_W-1:0]   ad_out_d;
  logic [2:0]        a_hi_d;

`ifdef FSMC_NWAIT_EN
  assign nwait_ok = NWAIT;
`else
  assign nwait_ok = 1'b1;
`endif

  fsmc_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .freeze   (cnt_freeze),
    .last     (cnt_last)
  );

  // The accept edge only captures the request; the bus phase starts one edge
  // later from the captured copy, which also yields the idle gap between
  // back-to-back transactions.
  always_comb begin
    state_d    = state;
    pending_d  = pending;
    accept     = 1'b0;
    rd_capture = 1'b0;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_freeze = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_freeze = 1'b1;
        if (pending) begin
          state_d   = ST_ADDR;
          pending_d = 1'b0;
          cnt_load  = 1'b1;
          cnt_val   = ADDSET_LD;
        end else if (REQ) begin
          accept    = 1'b1;
          pending_d = 1'b1;
        end
      end
      ST_ADDR: if (cnt_last) begin
        state_d  = ST_AHOLD;
        cnt_load = 1'b1;
        cnt_val  = ADDHLD_LD;
      end
      ST_AHOLD: if (cnt_last) begin
        state_d  = ST_DATA;
        cnt_load = 1'b1;
        cnt_val  = DATAST_LD;
      end
      ST_DATA: if (cnt_last) begin
        if (nwait_ok) begin
          state_d    = ST_TURN;
          cnt_load   = 1'b1;
          cnt_val    = BUSTURN_LD;
          rd_capture = !wr_q;
        end else begin
          cnt_freeze = 1'b1;
        end
      end
      ST_TURN: if (cnt_last) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = pending_d || (state_d != ST_IDLE);

  // Bus pins are decoded from the next state so they are registered yet
  // aligned with the state they belong to.
  always_comb begin
    ne_d     = 1'b1;
    nadv_d   = 1'b1;
    noe_d    = 1'b1;
    nwe_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = AD_OUT;
    a_hi_d   = {A18, A17, A16};
    case (state_d)
      ST_ADDR: begin
        ne_d     = 1'b0;
        nadv_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q[AD_W-1:0];
        a_hi_d   = addr_q[ADDR_W-1:AD_W];
      end
      ST_AHOLD: begin
        ne_d    = 1'b0;
        ad_oe_d = 1'b1;
      end
      ST_DATA: begin
        ne_d = 1'b0;
        if (wr_q) begin
          nwe_d    = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_q;
        end else begin
          noe_d = 1'b0;
        end
      end
      // Write data stays driven through turnaround as hold time after NWE.
      ST_TURN: ad_oe_d = wr_q;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RDATA   <= '0;
      NE      <= 1'b1;
      NADV    <= 1'b1;
      NOE     <= 1'b1;
      NWE     <= 1'b1;
      AD_OE   <= 1'b0;
      AD_OUT  <= '0;
      {A18, A17, A16} <= 3'b000;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      if (accept) begin
        wr_q    <= WR;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
      end
      if (rd_capture) begin
        RDATA <= AD_IN;
      end
      BUSY    <= busy_d;
      DONE    <= done_d;
      NE      <= ne_d;
      NADV    <= nadv_d;
      NOE     <= noe_d;
      NWE     <= nwe_d;
      AD_OE   <= ad_oe_d;
      AD_OUT  <= ad_out_d;
      {A18, A17, A16} <= a_hi_d;
    end
  end

endmodule

// File: tb/tb_fsmc_mux_master.sv
// tb/tb_fsmc_mux_master.sv - directed self-checking bench for fsmc_mux_master
module tb_fsmc_mux_master;

  logic        CLK = 1'b0;
  logic        RST, REQ, WR;
  logic [18:0] ADDR;
  logic [15:0] WDATA, RDATA, AD_OUT, AD_IN;
  logic        BUSY, DONE, NE, NADV, NOE, NWE, A16, A17, A18, AD_OE;
`ifdef FSMC_NWAIT_EN
  logic        NWAIT;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // responder model: address latch on NADV rise, write on NWE rise, read on NOE low
  logic        use_resp;
  logic [15:0] ad_in_drv;
  logic [18:0] resp_addr;
  logic [15:0] resp_mem [0:15];
  logic [15:0] ad_bus;

  assign ad_bus = AD_OE ? AD_OUT : (NOE ? 16'h0000 : resp_mem[resp_addr[3:0]]);
  assign AD_IN  = use_resp ? ad_bus : ad_in_drv;

  always @(posedge NADV) resp_addr <= {A18, A17, A16, ad_bus};
  always @(posedge NWE) resp_mem[resp_addr[3:0]] <= ad_bus;

  always #5 CLK = ~CLK;

  fsmc_mux_master dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .WR     (WR),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RDATA  (RDATA),
    .NE     (NE),
    .NADV   (NADV),
    .NOE    (NOE),
    .NWE    (NWE),
    .A16    (A16),
    .A17    (A17),
    .A18    (A18),
    .AD_OUT (AD_OUT),
    .AD_OE  (AD_OE),
    .AD_IN  (AD_IN)
`ifdef FSMC_NWAIT_EN
    ,
    .NWAIT  (NWAIT)
`endif
  );

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [15:0] ad_in;
    int          extra;
    int          exp_nadv;
    int          exp_nwe;
    int          exp_noe;
    int          exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [18:0] addr, input logic [15:0] wdata,
                              input logic [15:0] ad_in, input int extra, input logic [15:0] exp_rdata);
    vec_t v;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.ad_in     = ad_in;
    v.extra     = extra;
    v.exp_nadv  = 2;
    v.exp_nwe   = wr ? 4 : 0;
    v.exp_noe   = wr ? 0 : 4 + extra;
    v.exp_done  = 9 + extra;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          s_nadv, s_nwe, s_noe, s_done_at, s_done_cnt;
  bit          s_addr_ok, s_data_ok, s_oe_ok, s_inv_ok, s_busy_ok, s_busy_done_ok;
  logic [15:0] s_rdata_done;

  // One transaction; cycle k is the cycle after the k-th edge following the accept edge.
  task automatic run_txn(input vec_t v);
    int last_rd;
    last_rd = 7 + v.extra;
    s_nadv = 0; s_nwe = 0; s_noe = 0; s_done_at = -1; s_done_cnt = 0;
    s_addr_ok = 1; s_data_ok = 1; s_oe_ok = 1; s_inv_ok = 1; s_busy_done_ok = 1;
    s_rdata_done = 16'hxxxx;
    @(posedge CLK); #1;
    REQ = 1'b1; WR = v.wr; ADDR = v.addr; WDATA = v.wdata; ad_in_drv = 16'hDEAD;
`ifdef FSMC_NWAIT_EN
    NWAIT = 1'b1;
`endif
    @(posedge CLK); #1;
    s_busy_ok = (BUSY === 1'b1) && (NE === 1'b1);
    REQ = 1'b0; WR = ~v.wr; ADDR = ~v.addr; WDATA = ~v.wdata;
    for (int k = 1; k <= 20 + v.extra; k++) begin
      @(posedge CLK); #1;
      if (!NADV) begin
        s_nadv++;
        if (!(AD_OE === 1'b1 && AD_OUT === v.addr[15:0] && {A18, A17, A16} === v.addr[18:16]))
          s_addr_ok = 0;
      end
      if (!NWE) begin
        s_nwe++;
        if (!(AD_OE === 1'b1 && AD_OUT === v.wdata)) s_data_ok = 0;
      end
      if (!NOE) begin
        s_noe++;
        if (AD_OE !== 1'b0) s_oe_ok = 0;
      end
      if ((!NOE && !NWE) || (!NADV && (!NOE || !NWE)) || ((!NADV || !NOE || !NWE) && NE))
        s_inv_ok = 0;
      if (DONE) begin
        s_done_cnt++;
        if (s_done_at < 0) begin
          s_done_at = k;
          s_rdata_done = RDATA;
          if (BUSY !== 1'b0) s_busy_done_ok = 0;
        end
      end
      ad_in_drv = (k == last_rd) ? v.ad_in : (16'hDEAD ^ 16'(k));
`ifdef FSMC_NWAIT_EN
      NWAIT = !(k >= 7 && k < 7 + v.extra);
`endif
    end
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    chk({tag, " busy_at_accept"}, 32'(s_busy_ok), 32'd1);
    chk({tag, " nadv_cycles"}, 32'(s_nadv), 32'(v.exp_nadv));
    chk({tag, " addr_phase"}, 32'(s_addr_ok), 32'd1);
    chk({tag, " nwe_cycles"}, 32'(s_nwe), 32'(v.exp_nwe));
    chk({tag, " noe_cycles"}, 32'(s_noe), 32'(v.exp_noe));
    if (v.wr) chk({tag, " write_data"}, 32'(s_data_ok), 32'd1);
    else      chk({tag, " ad_oe_in_read"}, 32'(s_oe_ok), 32'd1);
    chk({tag, " strobe_rules"}, 32'(s_inv_ok), 32'd1);
    chk({tag, " done_latency"}, 32'(s_done_at), 32'(v.exp_done));
    chk({tag, " done_pulses"}, 32'(s_done_cnt), 32'd1);
    chk({tag, " busy_low_at_done"}, 32'(s_busy_done_ok), 32'd1);
    chk({tag, " rdata_at_done"}, 32'(s_rdata_done), 32'(v.exp_rdata));
  endtask

  vec_t vecs[4];
  vec_t lv;
  int   accepts, dones, ne_run, min_gap, seen;
  int   d[3];
  bit   prev_busy, seen_low;

  initial begin
    for (int i = 0; i < 16; i++) resp_mem[i] = 16'h0000;
    use_resp = 1'b0; ad_in_drv = 16'h0000;
    RST = 1'b1; REQ = 1'b0; WR = 1'b0; ADDR = '0; WDATA = '0;
`ifdef FSMC_NWAIT_EN
    NWAIT = 1'b1;
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk("reset strobes NE_NADV_NOE_NWE", 32'({NE, NADV, NOE, NWE}), 32'hF);
    chk("reset ad_oe_busy_done", 32'({AD_OE, BUSY, DONE}), 32'h0);
    chk("reset ad_out", 32'(AD_OUT), 32'h0);
    chk("reset a_lines", 32'({A18, A17, A16}), 32'h0);
    chk("reset rdata", 32'(RDATA), 32'h0);
    RST = 1'b0;

    vecs[0] = mk(1'b1, 19'h5_0012, 16'hA5C3, 16'h0000, 0, 16'h0000);
    vecs[1] = mk(1'b0, 19'h7_8000, 16'h0000, 16'h1234, 0, 16'h1234);
    vecs[2] = mk(1'b1, 19'h2_FFFF, 16'h0001, 16'h0000, 0, 16'h1234);
    vecs[3] = mk(1'b0, 19'h0_0000, 16'h0000, 16'h8001, 0, 16'h8001);
    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i]);
      check_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // back-to-back: REQ held high across three writes
    @(posedge CLK); #1;
    REQ = 1'b1; WR = 1'b1; ADDR = 19'h3_0100; WDATA = 16'h1111;
    prev_busy = 0; accepts = 0; dones = 0; ne_run = 0; min_gap = 99; seen_low = 0;
    d[0] = 0; d[1] = 0; d[2] = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge CLK); #1;
      if (BUSY && !prev_busy) begin
        accepts++;
        if (accepts == 3) REQ = 1'b0;
      end
      prev_busy = BUSY;
      if (DONE) begin
        if (dones < 3) d[dones] = k;
        dones++;
      end
      if (NE) ne_run++;
      else begin
        if (seen_low && ne_run > 0 && ne_run < min_gap) min_gap = ne_run;
        seen_low = 1;
        ne_run = 0;
      end
    end
    REQ = 1'b0;
    chk("b2b accepts", 32'(accepts), 32'd3);
    chk("b2b done_pulses", 32'(dones), 32'd3);
    chk("b2b done_spacing_1", 32'(d[1] - d[0]), 32'd10);
    chk("b2b done_spacing_2", 32'(d[2] - d[1]), 32'd10);
    chk("b2b ne_gap_at_least_2", 32'(min_gap >= 2), 32'd1);

    // reset in the second DATA cycle of a write
    @(posedge CLK); #1;
    REQ = 1'b1; WR = 1'b1; ADDR = 19'h1_2345; WDATA = 16'h5A5A;
    @(posedge CLK); #1;
    REQ = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("rst pre nwe_low", 32'(NWE), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst NE_NWE_NOE_NADV", 32'({NE, NWE, NOE, NADV}), 32'hF);
    chk("rst ad_oe_busy_done", 32'({AD_OE, BUSY, DONE}), 32'h0);
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
    chk("rst no_done", 32'(seen), 32'd0);

    // loopback through the responder model
    use_resp = 1'b1;
    lv = mk(1'b1, 19'h5_0003, 16'hBEEF, 16'h0000, 0, 16'h0000);
    run_txn(lv);
    check_txn("loop_wr", lv);
    chk("loop_wr latched_addr", 32'(resp_addr), 32'h5_0003);
    lv = mk(1'b1, 19'h5_0007, 16'h0F0F, 16'h0000, 0, 16'h0000);
    run_txn(lv);
    chk("loop_wr2 latched_addr", 32'(resp_addr), 32'h5_0007);
    lv = mk(1'b0, 19'h5_0003, 16'h0000, 16'h0000, 0, 16'hBEEF);
    run_txn(lv);
    check_txn("loop_rd", lv);
    chk("loop_rd latched_addr", 32'(resp_addr), 32'h5_0003);
    use_resp = 1'b0;

`ifdef FSMC_NWAIT_EN
    lv = mk(1'b0, 19'h6_4321, 16'h0000, 16'hC0DE, 3, 16'hC0DE);
    run_txn(lv);
    check_txn("nwait_rd", lv);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsmc_mux_master.md
Name: fsmc_mux_master

Overview:
- Bus initiator for the 16-bit multiplexed address/data MCU bus: drives NE, NADV, NOE and NWE, the AD[15:0] lines and the A16..A18 lines.
- It is the counterpart of the FPGA-side address-latch / buffer responder. The responder latches {A18,A17,A16,AD} on the rising edge of NADV, is read on NOE low and is written on NWE high.
- Used for FPGA-to-FPGA links and for self-test loopback of the responder logic.
- A single-transaction request/done handshake on the user side. Phase timing is fixed by parameters in CLK cycles.

Parameters:
- ADDSET, 2, cycles NADV is held low with the address on AD (min 1).
- ADDHLD, 1, cycles the address is held on AD after NADV rises (min 1).
- DATAST, 4, cycles NOE or NWE is held low (min 1).
- BUSTURN, 1, cycles NE is high after the data phase before returning to idle (min 1).
- CNT_W, 4, phase counter width; each timing parameter must be at most 2^CNT_W.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- REQ  in  1  transaction request, sampled only when BUSY=0
- WR  in  1  1=write, 0=read; captured with REQ
- ADDR  in  19  byte address {A18..A16, AD[15:0]}; captured with REQ
- WDATA  in  16  write data; captured with REQ
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle pulse when the transaction completes
- RDATA  out  16  read data; valid from the DONE pulse onward
- NE  out  1  chip enable, active-low
- NADV  out  1  address valid, active-low
- NOE  out  1  output enable (read strobe), active-low
- NWE  out  1  write enable, active-low
- A16, A17, A18  out  1 each  upper address lines
- AD_OUT  out  16  AD drive value
- AD_OE  out  1  AD tristate enable (1 = drive AD_OUT); the pad is instantiated at top level
- AD_IN  in  16  AD pad input

Behaviour:
- All outputs are registered.
- Reset values: NE=NADV=NOE=NWE=1, AD_OE=0, AD_OUT=0, A16..A18=0, BUSY=0, DONE=0, RDATA=0.
- States: IDLE, ADDR, AHOLD, DATA, TURN. One down-counter is loaded at each state entry.
- IDLE:
  - REQ=1 at an edge latches WR, ADDR and WDATA, and enters ADDR at the next edge.
  - BUSY rises at that edge.
- ADDR (ADDSET cycles): NE=0, NADV=0, AD_OE=1, AD_OUT=ADDR[15:0], A18..A16=ADDR[18:16].
- AHOLD (ADDHLD cycles):
  - NADV=1; the rising edge of NADV is the responder's latch point.
  - AD and A lines unchanged.
- DATA (DATAST cycles), write:
  - AD_OUT=WDATA, AD_OE=1, NWE=0.
  - NWE rises on exit.
- DATA (DATAST cycles), read:
  - AD_OE=0 from the first DATA cycle, NOE=0.
  - AD_IN is registered into RDATA at the edge that leaves DATA. This is the last cycle with NOE low.
  - NOE rises on exit.
- TURN (BUSTURN cycles):
  - NE=1, all strobes high.
  - Write: AD_OE and WDATA are held through TURN (data hold after NWE). AD_OE drops on entry to IDLE.
  - Read: AD_OE stays 0.
- Exit from TURN to IDLE: DONE=1 for one cycle, BUSY=0 at the same edge.
- Latency: accept edge to DONE = ADDSET+ADDHLD+DATAST+BUSTURN+1 cycles.
- NOE and NWE are never low in the same cycle. NADV is never low while NOE or NWE is low.
- REQ while BUSY=1 is ignored; no queueing.
- REQ held high continuously starts the next transaction in the IDLE cycle after DONE, giving a minimum one-cycle idle gap.
- Inputs captured at accept; changes to ADDR, WDATA or WR during BUSY have no effect.
- RDATA holds its value until the next read completes; writes do not alter it.
- RST mid-transaction: next edge returns to the reset values (strobes high, AD released), IDLE, no DONE pulse.
- A timing parameter of 0 is illegal. Elaboration fails via a generate-time check.

Optional Feature:
- Macro: FSMC_NWAIT_EN.
- Defined:
  - Adds input port NWAIT (1 bit, active-low, externally synchronised).
  - In DATA, when the counter reaches its last cycle and NWAIT=0, the state holds, with strobes kept low and the counter frozen.
  - DATA exits on the first edge with NWAIT=1. RDATA samples AD_IN at that exit edge.
  - NWAIT is ignored outside DATA.
- Undefined: no NWAIT port; DATA is exactly DATAST cycles.

Decomposition:
- Package fsmc_pkg: state enum (IDLE, ADDR, AHOLD, DATA, TURN), default timing constants, bus widths (AD_W=16, ADDR_W=19).
- One sub-module, fsmc_phase_cnt: a loadable down-counter with a last-cycle flag and a freeze input (freeze is used by NWAIT).

Test Plan:
- Write, defaults, ADDR=19'h5_0012, WDATA=16'hA5C3:
  - NADV low 2 cycles with AD=16'h0012 and A18..A16=3'b101.
  - NWE low 4 cycles with AD=16'hA5C3.
  - DONE exactly 9 cycles after the accept edge.
- Read, defaults, ADDR=19'h7_8000, AD_IN=16'h1234 on the last NOE-low cycle:
  - RDATA=16'h1234 at DONE.
  - AD_OE=0 for the entire NOE-low window.
- Back-to-back REQ held high for 3 writes: three DONE pulses 10 cycles apart; NE high for at least 2 cycles between transactions.
- RST asserted in the 2nd DATA cycle of a write: next cycle NE=NWE=1, AD_OE=0, BUSY=0; no DONE.
- Loopback with the responder, address 19'h5_xxxx: a write then a read returns the written value; the responder latch sees the full 19-bit address at the NADV rise.
- FSMC_NWAIT_EN, read with NWAIT low for 3 extra cycles: NOE low for 7 cycles; DONE at cycle 12; RDATA sampled at the NWAIT release edge.
